// File: rtl/button_conditioner.sv
// Synchronises and debounces the rock/paper/scissors/stop buttons, then latches one choice.
// Define BUTTON_SYNC_EN to put a 2-flop synchroniser in front of every raw input.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3
) (
   input  logic       clock,
   input  logic       reset_button,
   input  logic       rock_raw,
   input  logic       paper_raw,
   input  logic       scissors_raw,
   input  logic       stop_raw,
   output logic [1:0] choice,
   output logic       locked,
   output logic       stop_pulse,
   output logic       conflict
);

   localparam int               NBTN     = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // Bit order everywhere: {stop, scissors, paper, rock}
   logic [NBTN-1:0] raw_p0;
   logic [NBTN-1:0] synced;

   assign raw_p0 = {stop_raw, scissors_raw, paper_raw, rock_raw};

`ifdef BUTTON_SYNC_EN
   logic [NBTN-1:0] sync_p1;
   logic [NBTN-1:0] sync_p2;

   // Synchroniser stages
   always_ff @(posedge clock or negedge reset_button) begin
      if (!reset_button) begin
         sync_p1 <= '0;
         sync_p2 <= '0;
      end else begin
         sync_p1 <= raw_p0;
         sync_p2 <= sync_p1;
      end
   end

   assign synced = sync_p2;
`else
   assign synced = raw_p0;
`endif

   logic [NBTN-1:0]  stable;
   logic [CNT_W-1:0] cnt [NBTN];

   // Debounce stage: a level moves only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_ff @(posedge clock or negedge reset_button) begin
      if (!reset_button) begin
         stable <= '0;
         for (int i = 0; i < NBTN; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NBTN; i++) begin
            if (synced[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               stable[i] <= synced[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   logic       rock_db;
   logic       paper_db;
   logic       scissors_db;
   logic       stop_db;
   logic       stop_prev;
   logic       stop_rise;
   logic [1:0] press_cnt;
   logic       one_hot;
   logic       multi;
   logic       any_choice;
   logic       any_db;
   logic [1:0] enc;

   assign {stop_db, scissors_db, paper_db, rock_db} = stable;

   assign press_cnt  = 2'(rock_db) + 2'(paper_db) + 2'(scissors_db);
   assign one_hot    = (press_cnt == 2'd1);
   assign multi      = (press_cnt >= 2'd2);
   assign any_choice = rock_db | paper_db | scissors_db;
   assign any_db     = |stable;
   assign stop_rise  = stop_db & ~stop_prev;

   // Only meaningful when one_hot is set
   always_comb begin
      enc = 2'b00;
      if (scissors_db) begin
         enc = 2'b11;
      end else if (paper_db) begin
         enc = 2'b10;
      end else if (rock_db) begin
         enc = 2'b01;
      end
   end

   state_t     state;
   state_t     state_nx;
   logic [1:0] choice_nx;
   logic       pulse_nx;

   always_comb begin
      state_nx  = state;
      choice_nx = choice;
      pulse_nx  = 1'b0;
      case (state)
         IDLE: begin
            choice_nx = 2'b00;
            if (one_hot) begin
               state_nx  = ARMED;
               choice_nx = enc;
            end
         end
         ARMED: begin
            // Stop only counts on a fresh edge with a single choice held
            if (stop_rise && one_hot) begin
               state_nx  = LOCKED;
               choice_nx = enc;
               pulse_nx  = 1'b1;
            end else if (one_hot) begin
               choice_nx = enc;
            end else if (!any_choice) begin
               state_nx  = IDLE;
               choice_nx = 2'b00;
            end
         end
         LOCKED: begin
            if (!any_db) begin
               state_nx  = IDLE;
               choice_nx = 2'b00;
            end
         end
         default: begin
            state_nx  = IDLE;
            choice_nx = 2'b00;
         end
      endcase
   end

   // Registered control and outputs
   always_ff @(posedge clock or negedge reset_button) begin
      if (!reset_button) begin
         state      <= IDLE;
         choice     <= 2'b00;
         locked     <= 1'b0;
         stop_pulse <= 1'b0;
         conflict   <= 1'b0;
         stop_prev  <= 1'b0;
      end else begin
         state      <= state_nx;
         choice     <= choice_nx;
         locked     <= (state_nx == LOCKED);
         stop_pulse <= pulse_nx;
         conflict   <= multi;
         stop_prev  <= stop_db;
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised scoreboard bench for button_conditioner against a windowed reference model.
module tb_button_conditioner;

   localparam int N = 4;
`ifdef BUTTON_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   localparam logic [3:0] ROCK  = 4'b0001;
   localparam logic [3:0] PAPER = 4'b0010;
   localparam logic [3:0] SCIS  = 4'b0100;
   localparam logic [3:0] STOP  = 4'b1000;

   logic       clock        = 1'b0;
   logic       reset_button = 1'b0;
   logic       rock_raw     = 1'b0;
   logic       paper_raw    = 1'b0;
   logic       scissors_raw = 1'b0;
   logic       stop_raw     = 1'b0;
   logic [1:0] choice;
   logic       locked;
   logic       stop_pulse;
   logic       conflict;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct packed {
      logic [1:0] choice;
      logic       locked;
      logic       pulse;
      logic       conflict;
   } exp_t;

   exp_t exp_q[$];

   button_conditioner #(.DEBOUNCE_CYCLES(N), .CNT_W(3)) dut (
      .clock        (clock),
      .reset_button (reset_button),
      .rock_raw     (rock_raw),
      .paper_raw    (paper_raw),
      .scissors_raw (scissors_raw),
      .stop_raw     (stop_raw),
      .choice       (choice),
      .locked       (locked),
      .stop_pulse   (stop_pulse),
      .conflict     (conflict)
   );

   always #5 clock = ~clock;

   // Reference model: raw history, synced history window, debounced levels, player mode
   logic [3:0] raw_hist[$];
   logic [3:0] syn_hist[$];
   logic [3:0] m_db      = '0;
   logic [3:0] m_db_prev = '0;
   int         m_mode    = 0;   // 0 idle, 1 armed, 2 locked
   logic [1:0] m_choice  = '0;

   task automatic model_step(input logic rst_n, input logic [3:0] raw, output exp_t e);
      logic [3:0] synced;
      logic [3:0] nxt;
      logic [2:0] rps;
      int         n;
      logic       rise;
      logic [1:0] pick;
      logic       pulse;
      logic       flip;
      e = '0;
      if (!rst_n) begin
         raw_hist.delete();
         syn_hist.delete();
         m_db      = '0;
         m_db_prev = '0;
         m_mode    = 0;
         m_choice  = '0;
         return;
      end
      raw_hist.push_back(raw);
      synced = (raw_hist.size() > SYNC_LAT) ? raw_hist[raw_hist.size() - 1 - SYNC_LAT] : 4'b0;
      while (raw_hist.size() > SYNC_LAT + 1) void'(raw_hist.pop_front());

      rps   = m_db[2:0];
      n     = $countones(rps);
      rise  = m_db[3] & ~m_db_prev[3];
      pick  = rps[2] ? 2'b11 : (rps[1] ? 2'b10 : 2'b01);
      pulse = 1'b0;
      if (m_mode == 0) begin
         if (n == 1) begin
            m_mode   = 1;
            m_choice = pick;
         end else begin
            m_choice = 2'b00;
         end
      end else if (m_mode == 1) begin
         if (n == 1 && rise) begin
            m_mode   = 2;
            m_choice = pick;
            pulse    = 1'b1;
         end else if (n == 1) begin
            m_choice = pick;
         end else if (n == 0) begin
            m_mode   = 0;
            m_choice = 2'b00;
         end
      end else begin
         if (m_db == 4'b0) begin
            m_mode   = 0;
            m_choice = 2'b00;
         end
      end
      e.choice   = m_choice;
      e.locked   = (m_mode == 2);
      e.pulse    = pulse;
      e.conflict = (n >= 2);

      // A level flips once the last N synced samples all disagree with it
      syn_hist.push_back(synced);
      if (syn_hist.size() > N) void'(syn_hist.pop_front());
      nxt = m_db;
      if (syn_hist.size() == N) begin
         for (int b = 0; b < 4; b++) begin
            flip = 1'b1;
            foreach (syn_hist[j]) begin
               if (syn_hist[j][b] == m_db[b]) flip = 1'b0;
            end
            if (flip) nxt[b] = ~m_db[b];
         end
      end
      m_db_prev = m_db;
      m_db      = nxt;
   endtask

   task automatic step(input logic rst_n, input logic [3:0] v);
      exp_t e;
      @(negedge clock);
      #2;
      reset_button = rst_n;
      {stop_raw, scissors_raw, paper_raw, rock_raw} = v;
      model_step(rst_n, v, e);
      exp_q.push_back(e);
   endtask

   task automatic hold(input logic rst_n, input logic [3:0] v, input int n);
      for (int i = 0; i < n; i++) step(rst_n, v);
   endtask

   task automatic async_reset_check(input string name);
      @(negedge clock);
      #2;
      reset_button = 1'b0;
      #1;
      total++;
      if ({choice, locked, stop_pulse, conflict} !== 5'b0) begin
         bad++;
         $display("FAIL %s: got choice=%b locked=%b pulse=%b conflict=%b want all zero",
                  name, choice, locked, stop_pulse, conflict);
      end
   endtask

   always @(negedge clock) begin : monitor
      exp_t e;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if ({choice, locked, stop_pulse, conflict} !== e) begin
            bad++;
            $display("FAIL scoreboard cyc=%0d: got choice=%b locked=%b pulse=%b conflict=%b want choice=%b locked=%b pulse=%b conflict=%b",
                     cyc, choice, locked, stop_pulse, conflict, e.choice, e.locked, e.pulse, e.conflict);
         end
      end
   end

   initial begin
      logic [2:0] rps;
      logic       stp;
      int         r;

      hold(1'b0, 4'b0, 3);
      hold(1'b1, 4'b0, 2);

      // Reset mid-debounce, then debounce must restart
      hold(1'b1, ROCK, 3);
      async_reset_check("reset_mid_debounce");
      hold(1'b0, ROCK, 2);
      hold(1'b1, ROCK, 10);

      // Lock on rock with a 60 ns stop press, then release
      hold(1'b1, ROCK | STOP, 6);
      hold(1'b1, ROCK, 8);
      hold(1'b1, 4'b0, 10);

      // Paper bounce before settling
      hold(1'b1, PAPER, 1);
      hold(1'b1, 4'b0, 1);
      hold(1'b1, PAPER, 12);
      hold(1'b1, 4'b0, 10);

      // Conflict from idle, stop ignored
      hold(1'b1, ROCK | SCIS, 10);
      hold(1'b1, ROCK | SCIS | STOP, 8);
      hold(1'b1, ROCK | SCIS, 4);
      hold(1'b1, 4'b0, 10);

      // Lock on scissors, paper ignored, release all
      hold(1'b1, SCIS, 10);
      hold(1'b1, SCIS | STOP, 8);
      hold(1'b1, SCIS, 4);
      hold(1'b1, SCIS | PAPER, 10);
      hold(1'b1, 4'b0, 10);

      // Stop held through arming does not lock; a fresh press does
      hold(1'b1, STOP, 10);
      hold(1'b1, STOP | ROCK, 10);
      hold(1'b1, ROCK, 8);
      hold(1'b1, ROCK | STOP, 8);
      hold(1'b1, ROCK, 3);
      async_reset_check("reset_while_locked");
      hold(1'b0, ROCK, 2);
      hold(1'b1, 4'b0, 10);

      // Randomised segments with glitches, conflicts and occasional reset
      for (int seg = 0; seg < 400; seg++) begin
         r = int'($urandom_range(0, 9));
         if (r < 6)      rps = 3'b001 << $urandom_range(0, 2);
         else if (r < 8) rps = 3'b000;
         else            rps = 3'($urandom_range(0, 7));
         stp = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 79) == 0) hold(1'b0, {stp, rps}, int'($urandom_range(1, 2)));
         else                            hold(1'b1, {stp, rps}, int'($urandom_range(1, 9)));
      end
      hold(1'b1, 4'b0, 12);

      @(negedge clock);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
